pixel_array_sequencer: RTL and testbench
========================================

// Module: pixel_array_sequencer
// PURPOSE
//  Frame-level controller for a parametrised ROWS x COLS pixel sensor array.
//  Sequences the global ERASE, EXPOSE and CONVERT phases and drives the shared
//  ADC ramp counter. It then reads the array row by row and streams each pixel
//  word out on a valid/ready interface, in row-major order.
//  Sits between the frame scheduler (start/abort) and the pixel-sensor array.
// PARAMETERS
//  ROWS       2   pixel rows; each row has its own read select line
//  COLS       2   pixels per row, all captured in parallel
//  DATA_W     8   pixel/ADC word width; a conversion lasts 2**DATA_W cycles
//  ERASE_CYC  4   clock cycles for which erase is held high
//  EXP_W      16  width of the runtime exposure-length input
// PORTS
//  clk        in   1             clock, rising edge
//  reset      in   1             asynchronous, active-high reset
//  start      in   1             one-cycle pulse starting a frame; sampled only in IDLE
//  abort      in   1             cancels the frame in progress
//  exp_len    in   EXP_W         exposure length in cycles; sampled when start is accepted
//  erase      out  1             global pixel erase
//  expose     out  1             global pixel expose
//  convert    out  1             ramp/compare phase active
//  cnt_oe     out  1             counter drives the pixel data bus
//  cnt_out    out  DATA_W        binary ADC ramp count
//  read       out  ROWS          one-hot row read select
//  pix_in     in   COLS*DATA_W   row data; column c occupies bits [c*DATA_W +: DATA_W]
//  out_data   out  DATA_W        pixel word
//  out_col    out  log2(COLS)    column index of out_data
//  out_row    out  log2(ROWS)    row index of out_data
//  out_last   out  1             high on the final word of the frame
//  out_valid  out  1             out_data is valid
//  out_ready  in   1             downstream accepts the word
//  busy       out  1             high in every state except IDLE
//  frame_done out  1             one-cycle pulse after the last word is accepted
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; row/column/phase counters 0.
//  FSM: IDLE -> ERASE -> EXPOSE -> CONVERT -> (LATCH -> STREAM) x ROWS -> DONE -> IDLE.
//  - IDLE: if start is high, latch max(exp_len,1) and go to ERASE on the next edge.
//  - ERASE: erase=1 for exactly ERASE_CYC cycles.
//  - EXPOSE: expose=1 for exactly the latched exposure length, in cycles.
//  - CONVERT: convert=1 and cnt_oe=1 for 2**DATA_W cycles.
//    - cnt_out=0 on the first cycle, +1 per cycle, ends at 2**DATA_W-1.
//    - cnt_out does not wrap; it returns to 0 on exit.
//  - LATCH: read[row]=1 (one-hot). pix_in is captured into a COLS-word buffer on
//    the edge that ends LATCH, 1 cycle after read rises.
//  - STREAM: read[row] stays high. Words are presented column 0..COLS-1, one per
//    accepted handshake.
//    - out_data, out_col and out_row are held stable while out_valid=1 and out_ready=0.
//    - out_valid stays high until the word is accepted; there are no bubbles
//      between the words of a row.
//    - After column COLS-1 is accepted: read goes low, row increments, and the
//      FSM enters LATCH. After the last row it enters DONE.
//  - out_last=1 only with row ROWS-1 and column COLS-1.
//  - DONE: frame_done=1 for 1 cycle, then IDLE. busy falls in the same cycle as
//    the return to IDLE.
//  Phases are mutually exclusive. At most one of erase, expose, convert and
//  read[*] is high in any cycle.
//  start outside IDLE is ignored (no queueing).
//  abort in any non-IDLE state: next edge -> IDLE, all outputs 0, no frame_done.
//  abort takes priority over start and out_ready in the same cycle.
//  Async reset mid-frame: outputs go to their reset values immediately, without
//  waiting for a clock edge.
//  Frame length with no stalls:
//    1 + ERASE_CYC + exp + 2**DATA_W + ROWS*(1+COLS) + 1 cycles.
// TESTING
//  1. ROWS=COLS=2, DATA_W=4, ERASE_CYC=4, exp_len=10, out_ready=1:
//     -> erase 4 cycles, expose 10 cycles, cnt_out 0..15 with cnt_oe=1,
//        4 words in order (r0c0, r0c1, r1c0, r1c1), out_last on word 4,
//        one frame_done pulse.
//  2. pix_in={8'hA5,8'h3C} for row 0 and {8'h11,8'hFF} for row 1 -> output
//     sequence 3C, A5, FF, 11.
//  3. out_ready low for 5 cycles on word 2 -> out_valid, out_data and out_col
//     are stable throughout; the word is taken exactly once.
//  4. exp_len=0 -> expose is high for exactly 1 cycle. start pulsed during
//     CONVERT -> ignored, and only one frame_done occurs.
//  5. abort on cycle 3 of CONVERT -> IDLE on the next edge; convert, cnt_oe and
//     cnt_out are 0; no frame_done. A following start runs a full frame.
//  6. reset asserted mid-STREAM -> all outputs 0 asynchronously; busy=0 after
//     release.

Source files
------------

// File: rtl/pixel_array_sequencer.sv
// ---------------------------------------------------------------------------
// pixel_array_sequencer
//
// Frame-level controller for a ROWS x COLS pixel sensor array. One frame runs
// the global ERASE, EXPOSE and CONVERT phases, drives the shared ADC ramp
// counter during CONVERT, and then reads the array one row at a time. Each
// pixel word is streamed out in row-major order on a valid/ready interface.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   start      in   one-cycle frame start pulse, honoured only when idle
//   abort      in   cancels the frame in progress (wins over start/out_ready)
//   exp_len    in   exposure length in cycles, latched when start is accepted
//   erase      out  global pixel erase
//   expose     out  global pixel expose
//   convert    out  ramp/compare phase active
//   cnt_oe     out  ramp counter drives the pixel data bus
//   cnt_out    out  binary ADC ramp count
//   read       out  one-hot row read select
//   pix_in     in   row data, column c in bits [c*DATA_W +: DATA_W]
//   out_data   out  pixel word
//   out_col    out  column index of out_data
//   out_row    out  row index of out_data
//   out_last   out  final word of the frame
//   out_valid  out  out_data is valid
//   out_ready  in   downstream accepts the word
//   busy       out  high in every state except IDLE
//   frame_done out  one-cycle pulse after the last word is accepted
//
// All outputs are registers. Each state branch assigns the output values
// that belong to the state being entered, so the outputs line up exactly
// with the state register.
// ---------------------------------------------------------------------------
module pixel_array_sequencer #(
    parameter int ROWS      = 2,
    parameter int COLS      = 2,
    parameter int DATA_W    = 8,
    parameter int ERASE_CYC = 4,
    parameter int EXP_W     = 16,
    localparam int ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int COL_W    = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [EXP_W-1:0]         exp_len,
    output logic                     erase,
    output logic                     expose,
    output logic                     convert,
    output logic                     cnt_oe,
    output logic [DATA_W-1:0]        cnt_out,
    output logic [ROWS-1:0]          read,
    input  logic [COLS*DATA_W-1:0]   pix_in,
    output logic [DATA_W-1:0]        out_data,
    output logic [COL_W-1:0]         out_col,
    output logic [ROW_W-1:0]         out_row,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     frame_done
);

    // Phase counter must hold both the erase length and any exposure length.
    localparam int ERASE_W = $clog2(ERASE_CYC + 1);
    localparam int CNT_W   = (EXP_W > ERASE_W) ? EXP_W : ERASE_W;

    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);
    localparam logic [CNT_W-1:0] ERASE_END = CNT_W'(ERASE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ERASE   = 3'd1,
        S_EXPOSE  = 3'd2,
        S_CONVERT = 3'd3,
        S_LATCH   = 3'd4,
        S_STREAM  = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t              state_r;
    logic [CNT_W-1:0]    phase_cnt_r;
    logic [EXP_W-1:0]    exp_r;
    logic [ROW_W-1:0]    row_r;
    logic [COL_W-1:0]    col_r;
    logic [DATA_W-1:0]   line_buf_r [COLS];

    logic [ROW_W-1:0]    row_next_s;
    logic [COL_W-1:0]    col_next_s;
    logic [CNT_W-1:0]    expose_end_s;
    logic                ramp_end_s;

    // One-hot row select for a given row index.
    function automatic logic [ROWS-1:0] row_onehot(input logic [ROW_W-1:0] r);
        logic [ROWS-1:0] v;
        v    = {ROWS{1'b0}};
        v[r] = 1'b1;
        return v;
    endfunction

    // Next row/column indices and phase end points used by the FSM.
    always_comb begin
        row_next_s   = row_r + ROW_W'(1);
        col_next_s   = col_r + COL_W'(1);
        // exp_r is never 0, it is clamped to 1 when latched.
        expose_end_s = CNT_W'(exp_r) - CNT_W'(1);
        ramp_end_s   = (cnt_out == {DATA_W{1'b1}});
    end

    // Frame sequencer: state, counters, line buffer and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= S_IDLE;
            phase_cnt_r <= {CNT_W{1'b0}};
            exp_r       <= {EXP_W{1'b0}};
            row_r       <= {ROW_W{1'b0}};
            col_r       <= {COL_W{1'b0}};
            for (int c = 0; c < COLS; c++) begin
                line_buf_r[c] <= {DATA_W{1'b0}};
            end
            erase       <= 1'b0;
            expose      <= 1'b0;
            convert     <= 1'b0;
            cnt_oe      <= 1'b0;
            cnt_out     <= {DATA_W{1'b0}};
            read        <= {ROWS{1'b0}};
            out_data    <= {DATA_W{1'b0}};
            out_col     <= {COL_W{1'b0}};
            out_row     <= {ROW_W{1'b0}};
            out_last    <= 1'b0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else if (abort && (state_r != S_IDLE)) begin
            // Abort drops the frame silently: no frame_done, straight to idle.
            state_r     <= S_IDLE;
            phase_cnt_r <= {CNT_W{1'b0}};
            row_r       <= {ROW_W{1'b0}};
            col_r       <= {COL_W{1'b0}};
            erase       <= 1'b0;
            expose      <= 1'b0;
            convert     <= 1'b0;
            cnt_oe      <= 1'b0;
            cnt_out     <= {DATA_W{1'b0}};
            read        <= {ROWS{1'b0}};
            out_data    <= {DATA_W{1'b0}};
            out_col     <= {COL_W{1'b0}};
            out_row     <= {ROW_W{1'b0}};
            out_last    <= 1'b0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        // A zero exposure still gives one expose cycle.
                        exp_r       <= (exp_len == {EXP_W{1'b0}}) ? EXP_W'(1) : exp_len;
                        phase_cnt_r <= {CNT_W{1'b0}};
                        row_r       <= {ROW_W{1'b0}};
                        col_r       <= {COL_W{1'b0}};
                        erase       <= 1'b1;
                        busy        <= 1'b1;
                        state_r     <= S_ERASE;
                    end else begin
                        busy        <= 1'b0;
                    end
                end

                S_ERASE: begin
                    if (phase_cnt_r == ERASE_END) begin
                        phase_cnt_r <= {CNT_W{1'b0}};
                        erase       <= 1'b0;
                        expose      <= 1'b1;
                        state_r     <= S_EXPOSE;
                    end else begin
                        phase_cnt_r <= phase_cnt_r + CNT_W'(1);
                    end
                end

                S_EXPOSE: begin
                    if (phase_cnt_r == expose_end_s) begin
                        phase_cnt_r <= {CNT_W{1'b0}};
                        expose      <= 1'b0;
                        convert     <= 1'b1;
                        cnt_oe      <= 1'b1;
                        cnt_out     <= {DATA_W{1'b0}};
                        state_r     <= S_CONVERT;
                    end else begin
                        phase_cnt_r <= phase_cnt_r + CNT_W'(1);
                    end
                end

                S_CONVERT: begin
                    // The ramp value itself times the conversion; it parks
                    // at zero on exit instead of wrapping.
                    if (ramp_end_s) begin
                        convert     <= 1'b0;
                        cnt_oe      <= 1'b0;
                        cnt_out     <= {DATA_W{1'b0}};
                        read        <= row_onehot(row_r);
                        state_r     <= S_LATCH;
                    end else begin
                        cnt_out     <= cnt_out + DATA_W'(1);
                    end
                end

                S_LATCH: begin
                    // Row data has had one full cycle behind its read select.
                    for (int c = 0; c < COLS; c++) begin
                        line_buf_r[c] <= pix_in[c*DATA_W +: DATA_W];
                    end
                    col_r       <= {COL_W{1'b0}};
                    out_data    <= pix_in[DATA_W-1:0];
                    out_col     <= {COL_W{1'b0}};
                    out_row     <= row_r;
                    out_last    <= (row_r == ROW_LAST) && (COLS == 1);
                    out_valid   <= 1'b1;
                    state_r     <= S_STREAM;
                end

                S_STREAM: begin
                    if (out_ready) begin
                        if (col_r == COL_LAST) begin
                            col_r       <= {COL_W{1'b0}};
                            out_data    <= {DATA_W{1'b0}};
                            out_col     <= {COL_W{1'b0}};
                            out_last    <= 1'b0;
                            out_valid   <= 1'b0;
                            if (row_r == ROW_LAST) begin
                                read        <= {ROWS{1'b0}};
                                out_row     <= {ROW_W{1'b0}};
                                frame_done  <= 1'b1;
                                state_r     <= S_DONE;
                            end else begin
                                // Old select drops and the next row's rises together.
                                row_r       <= row_next_s;
                                read        <= row_onehot(row_next_s);
                                state_r     <= S_LATCH;
                            end
                        end else begin
                            col_r       <= col_next_s;
                            out_col     <= col_next_s;
                            out_data    <= line_buf_r[col_next_s];
                            out_last    <= (row_r == ROW_LAST) && (col_next_s == COL_LAST);
                        end
                    end else begin
                        // Stalled: re-present the buffered word (unchanged value).
                        out_data    <= line_buf_r[col_r];
                    end
                end

                S_DONE: begin
                    frame_done  <= 1'b0;
                    busy        <= 1'b0;
                    row_r       <= {ROW_W{1'b0}};
                    state_r     <= S_IDLE;
                end

                default: begin
                    state_r     <= S_IDLE;
                    phase_cnt_r <= {CNT_W{1'b0}};
                    row_r       <= {ROW_W{1'b0}};
                    col_r       <= {COL_W{1'b0}};
                    erase       <= 1'b0;
                    expose      <= 1'b0;
                    convert     <= 1'b0;
                    cnt_oe      <= 1'b0;
                    cnt_out     <= {DATA_W{1'b0}};
                    read        <= {ROWS{1'b0}};
                    out_data    <= {DATA_W{1'b0}};
                    out_col     <= {COL_W{1'b0}};
                    out_row     <= {ROW_W{1'b0}};
                    out_last    <= 1'b0;
                    out_valid   <= 1'b0;
                    busy        <= 1'b0;
                    frame_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_array_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for pixel_array_sequencer (ROWS=COLS=2, DATA_W=8, ERASE_CYC=4).
// A small array model answers the row read selects with per-row pixel data.
// Expected pixel words are queued when a frame is started and popped as the
// DUT hands words over; phase lengths, ramp values and frame timing are
// derived from the frame parameters.
// ---------------------------------------------------------------------------
module tb_pixel_array_sequencer;

    localparam int ROWS      = 2;
    localparam int COLS      = 2;
    localparam int DW        = 8;
    localparam int ERASE_CYC = 4;
    localparam int EXP_W     = 16;
    localparam int CONV_CYC  = 1 << DW;
    localparam int BUDGET    = 3000;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic                 abort;
    logic [EXP_W-1:0]     exp_len;
    logic                 erase, expose, convert, cnt_oe;
    logic [DW-1:0]        cnt_out;
    logic [ROWS-1:0]      read;
    logic [COLS*DW-1:0]   pix_in;
    logic [DW-1:0]        out_data;
    logic                 out_col;
    logic                 out_row;
    logic                 out_last, out_valid, out_ready, busy, frame_done;

    logic [COLS*DW-1:0]   row0_pix;
    logic [COLS*DW-1:0]   row1_pix;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          col;
        logic          row;
        logic          last;
    } word_t;

    word_t exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    wire [27:0] all_out = {erase, expose, convert, cnt_oe, cnt_out, read, out_data,
                           out_col, out_row, out_last, out_valid, busy, frame_done};

    pixel_array_sequencer #(
        .ROWS(ROWS), .COLS(COLS), .DATA_W(DW), .ERASE_CYC(ERASE_CYC), .EXP_W(EXP_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .exp_len(exp_len),
        .erase(erase), .expose(expose), .convert(convert), .cnt_oe(cnt_oe),
        .cnt_out(cnt_out), .read(read), .pix_in(pix_in), .out_data(out_data),
        .out_col(out_col), .out_row(out_row), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Pixel array model: a row drives its data only while selected.
    always_comb begin
        if (read[0])      pix_in = row0_pix;
        else if (read[1]) pix_in = row1_pix;
        else              pix_in = {(COLS*DW){1'b0}};
    end

    task automatic push_frame_words();
        logic [COLS*DW-1:0] rp;
        word_t w;
        for (int r = 0; r < ROWS; r++) begin
            rp = (r == 0) ? row0_pix : row1_pix;
            for (int c = 0; c < COLS; c++) begin
                w.data = rp[c*DW +: DW];
                w.col  = c[0];
                w.row  = r[0];
                w.last = (r == ROWS-1) && (c == COLS-1);
                exp_q.push_back(w);
            end
        end
    endtask

    // Runs one frame from the start pulse to the return to idle and checks it.
    task automatic run_frame(input int expv, input int stall_word, input int stall_len,
                             input bit start_in_conv, input string name);
        int erase_n = 0, expose_n = 0, conv_n = 0, ramp_err = 0, excl_err = 0;
        int busy_err = 0, stab_err = 0, word_idx = 0, held = 0, done_k = -1;
        int idle_err = 0, expc, want_k;
        bit done_seen = 1'b0;
        word_t w, got, hold_w;
        expc   = (expv == 0) ? 1 : expv;
        want_k = ERASE_CYC + expc + CONV_CYC + ROWS*(1+COLS) + stall_len;
        @(negedge clk);
        exp_len = expv[EXP_W-1:0];
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        exp_len = 16'd777;   // must not affect the running frame
        for (int k = 0; k < BUDGET; k++) begin
            start = 1'b0;
            if (erase)  erase_n++;
            if (expose) expose_n++;
            if ($countones({erase, expose, convert, read}) > 1) excl_err++;
            if (busy !== 1'b1) busy_err++;
            if (convert === 1'b1) begin
                if (cnt_out !== conv_n[DW-1:0] || cnt_oe !== 1'b1) ramp_err++;
                conv_n++;
                if (start_in_conv && conv_n == 4) start = 1'b1;
            end else if (cnt_oe !== 1'b0 || cnt_out !== {DW{1'b0}}) begin
                ramp_err++;
            end
            out_ready = 1'b1;
            if (out_valid === 1'b1) begin
                got = {out_data, out_col, out_row, out_last};
                if (word_idx == stall_word && held < stall_len) begin
                    if (held == 0) hold_w = got;
                    else if (got !== hold_w) stab_err++;
                    out_ready = 1'b0;
                    held++;
                end else begin
                    if (word_idx == stall_word && held > 0 && got !== hold_w) stab_err++;
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL %s word%0d: got unexpected word %h, required none", name, word_idx, got);
                    end else begin
                        w = exp_q.pop_front();
                        if (got !== w)
                            $display("FAIL %s word%0d: got data/col/row/last %h, required %h", name, word_idx, got, w);
                        else
                            n_pass++;
                    end
                    word_idx++;
                end
            end
            if (frame_done === 1'b1) begin
                done_seen = 1'b1;
                done_k    = k;
                break;
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        n_checks++;
        if (!done_seen) $display("FAIL %s timeout: got no frame_done, required one within %0d cycles", name, BUDGET);
        else n_pass++;
        n_checks++;
        if (erase_n !== ERASE_CYC) $display("FAIL %s erase_len: got %0d, required %0d", name, erase_n, ERASE_CYC);
        else n_pass++;
        n_checks++;
        if (expose_n !== expc) $display("FAIL %s expose_len: got %0d, required %0d", name, expose_n, expc);
        else n_pass++;
        n_checks++;
        if (conv_n !== CONV_CYC) $display("FAIL %s convert_len: got %0d, required %0d", name, conv_n, CONV_CYC);
        else n_pass++;
        n_checks++;
        if (ramp_err !== 0) $display("FAIL %s ramp: got %0d bad cycles, required 0", name, ramp_err);
        else n_pass++;
        n_checks++;
        if (excl_err !== 0) $display("FAIL %s exclusive: got %0d overlap cycles, required 0", name, excl_err);
        else n_pass++;
        n_checks++;
        if (busy_err !== 0) $display("FAIL %s busy: got %0d low cycles in frame, required 0", name, busy_err);
        else n_pass++;
        n_checks++;
        if (word_idx !== ROWS*COLS || exp_q.size() !== 0)
            $display("FAIL %s word_count: got %0d words (%0d unsent), required %0d", name, word_idx, exp_q.size(), ROWS*COLS);
        else n_pass++;
        n_checks++;
        if (done_k !== want_k) $display("FAIL %s frame_len: got done at %0d, required %0d", name, done_k, want_k);
        else n_pass++;
        if (stall_word >= 0) begin
            n_checks++;
            if (stab_err !== 0 || held !== stall_len)
                $display("FAIL %s stall_stable: got %0d changes over %0d held cycles, required 0 over %0d", name, stab_err, held, stall_len);
            else n_pass++;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || frame_done !== 1'b0) idle_err++;
        end
        n_checks++;
        if (idle_err !== 0) $display("FAIL %s idle_after_done: got %0d busy/done cycles, required 0", name, idle_err);
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1; exp_len = 16'd0;
        row0_pix = 16'h0000; row1_pix = 16'h0000;
        repeat (2) @(negedge clk);
        n_checks++;
        if (all_out !== 28'd0) $display("FAIL reset_held: got outputs %h, required 0", all_out);
        else n_pass++;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (all_out !== 28'd0) $display("FAIL reset_idle: got outputs %h, required 0", all_out);
        else n_pass++;
    endtask

    task automatic test_basic_frame();
        row0_pix = {8'hA5, 8'h3C};
        row1_pix = {8'h11, 8'hFF};
        exp_q.push_back({8'h3C, 1'b0, 1'b0, 1'b0});
        exp_q.push_back({8'hA5, 1'b1, 1'b0, 1'b0});
        exp_q.push_back({8'hFF, 1'b0, 1'b1, 1'b0});
        exp_q.push_back({8'h11, 1'b1, 1'b1, 1'b1});
        run_frame(10, -1, 0, 1'b0, "basic");
    endtask

    task automatic test_stall();
        row0_pix = {8'h5A, 8'hC3};
        row1_pix = {8'h7E, 8'h81};
        push_frame_words();
        run_frame(6, 1, 5, 1'b0, "stall");
    endtask

    task automatic test_zero_exp_start_ignored();
        row0_pix = {8'h02, 8'h01};
        row1_pix = {8'h04, 8'h03};
        push_frame_words();
        run_frame(0, -1, 0, 1'b1, "zero_exp");
    endtask

    task automatic test_abort();
        bit found = 1'b0;
        int done_n = 0, busy_n = 0;
        @(negedge clk);
        exp_len = 16'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < BUDGET; k++) begin
            if (convert === 1'b1 && cnt_out === 8'd2) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (!found) $display("FAIL abort_reach: got no CONVERT cycle 3, required one within %0d cycles", BUDGET);
        else n_pass++;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if (all_out !== 28'd0) $display("FAIL abort_outputs: got outputs %h, required 0", all_out);
        else n_pass++;
        for (int i = 0; i < 20; i++) begin
            if (frame_done === 1'b1) done_n++;
            if (busy === 1'b1) busy_n++;
            @(negedge clk);
        end
        n_checks++;
        if (done_n !== 0 || busy_n !== 0)
            $display("FAIL abort_quiet: got %0d frame_done and %0d busy cycles, required 0 and 0", done_n, busy_n);
        else n_pass++;
        row0_pix = {8'hDE, 8'hAD};
        row1_pix = {8'hBE, 8'hEF};
        push_frame_words();
        run_frame(3, -1, 0, 1'b0, "after_abort");
    endtask

    task automatic test_async_reset();
        bit found = 1'b0;
        @(negedge clk);
        exp_len = 16'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < BUDGET; k++) begin
            if (out_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (!found) $display("FAIL areset_reach: got no STREAM word, required one within %0d cycles", BUDGET);
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (all_out !== 28'd0) $display("FAIL areset_async: got outputs %h before clock edge, required 0", all_out);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || all_out !== 28'd0) $display("FAIL areset_release: got outputs %h, required 0", all_out);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_stall();
        test_zero_exp_start_ignored();
        test_abort();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
